msftdvip_plic_mt: RTL and testbench
===================================

// Module: msftdvip_plic_mt
// PURPOSE
//  Multi-target platform-level interrupt controller for the CHERIoT subsystem MMIO fabric.
//  Gathers NSRC level- or edge-triggered sources and routes them to NTGT interrupt targets
//  (e.g. M-mode core, debug/monitor hart), each with its own enables, threshold and claim.
//  Per-source gateway: one outstanding request per source until completion. Edge sources
//  keep a one-deep edge memory, so an edge arriving while the source is blocked is not lost.
// PARAMETERS
//  NSRC  31  number of sources, 1..31; source ids 1..NSRC, id 0 = "no interrupt"
//  NTGT   2  number of targets, 1..8
//  PRIW   3  priority width in bits, 1..7; priority 0 = never interrupts
// PORTS
//  clk_i        in   1     clock
//  rstn_i       in   1     asynchronous, active-low reset
//  reg_en_i     in   1     MMIO access strobe, single cycle
//  reg_we_i     in   1     1 = write, 0 = read
//  reg_addr_i   in   32    byte address; only [25:2] decoded
//  reg_wdata_i  in   32    write data
//  reg_rdata_o  out  32    read data, valid the cycle after the read strobe
//  reg_ready_o  out  1     tied 1; no wait states
//  irqs_i       in   NSRC  raw sources; irqs_i[k] is source id k+1
//  irq_o        out  NTGT  per-target interrupt notification (EIP)
// BEHAVIOUR
//  Register map (byte offsets); unmapped reads return 0, unmapped writes are ignored.
//   0x000000+4*id  priority[id] RW, [PRIW-1:0]; id 0 reads 0
//   0x001000       pending RO, bit id; bit 0 = 0
//   0x001080       edge_mode RW, bit id: 1 = rising-edge, 0 = level
//   0x002000+0x80*t   enable[t] RW, bit id
//   0x200000+0x1000*t threshold[t] RW, [PRIW-1:0]
//   0x200004+0x1000*t claim[t] on read, complete[t] on write
//  Reset: all registers, pending, blocked, edge memory, irqs_q, irq_o and reg_rdata_o are 0.
//   Reset mid-operation drops every in-flight claim.
//  Gateway per source, states IDLE -> PEND -> BLOCKED -> IDLE:
//   IDLE->PEND when sig=1, where sig is the raw level (level mode) or irqs_i & ~irqs_q (edge).
//   PEND->BLOCKED on a claim returning this id, from any target.
//   BLOCKED->IDLE on a complete with this id from any target whose enable[t] bit is set.
//   BLOCKED: an edge-mode edge sets edge_mem. On complete with edge_mem=1 -> PEND, edge_mem cleared.
//   Level mode re-pends on the next cycle if the line is still high.
//   Complete with id 0, id > NSRC, a non-BLOCKED source, or a cleared enable bit: ignored.
//  Arbitration per target:
//   best[t] is the max priority over sources that are pending, enabled[t] and priority > 0.
//   Ties go to the lower id. Implemented as a combinational tree over NSRC.
//   irq_o[t] is registered: 1 the cycle after best_pri[t] > threshold[t].
//   Latency: source asserted -> pending +1 cycle -> irq_o +2 cycles.
//  Claim read:
//   Returns best_id[t] evaluated in the strobe cycle, ignoring threshold; 0 if none.
//   The returned id's pending bit clears at the same edge.
//   The next claim in the following cycle sees the updated state (no duplicate id).
//  Simultaneous events on one source: claim beats sig in the same cycle (source goes BLOCKED).
//   Complete and a new sig in the same cycle: the source goes IDLE, the sig is sampled next cycle.
//  Writes to priority/enable/threshold take effect on the arbitration of the following cycle.
//   Disabling a pending source leaves it pending.
//  Sim-only asserts: NSRC <= 31, NTGT <= 8, PRIW <= 7.
// TESTING
//  1 Level src 3, pri 5, en[0]={3}, thr 2 -> irq_o[0]=1 two cycles later.
//    Claim[0] returns 3, irq_o[0]=0. Hold the line, complete 3 -> re-pends, irq_o[0]=1 again.
//  2 Srcs 4 and 9 both pri 6, en[0] both -> claims return 4, then 9.
//    Set pri[9]=7 before the first claim -> returns 9.
//  3 Edge src 7 pulsed twice while BLOCKED -> one retained edge.
//    Complete 7 -> pending again. Next claim returns 7, then after complete claim returns 0.
//  4 Src 2 pri 4: thr[0]=4 -> irq_o[0]=0 but claim[0] returns 2. thr[1]=1, en[1]={2} -> irq_o[1]=1.
//  5 Complete with id 0, id 40, and an unclaimed id -> no state change.
//    Complete from a target with the enable bit cleared -> source stays BLOCKED.
//  6 Assert rstn_i=0 mid-claim with src 5 BLOCKED -> all outputs 0.
//    After release, level src 5 high -> pending, irq_o only after enable and priority are reprogrammed.

Source files
------------

// File: rtl/msftdvip_plic_mt.sv
// Multi-target PLIC: per-source gateways feeding per-target priority arbiters, with
// an MMIO register file for priorities, enables, thresholds and claim/complete.
module msftdvip_plic_mt #(
  parameter int unsigned NSRC = 31,
  parameter int unsigned NTGT = 2,
  parameter int unsigned PRIW = 3
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            reg_en_i,
  input  logic            reg_we_i,
  input  logic [31:0]     reg_addr_i,
  input  logic [31:0]     reg_wdata_i,
  output logic [31:0]     reg_rdata_o,
  output logic            reg_ready_o,
  input  logic [NSRC-1:0] irqs_i,
  output logic [NTGT-1:0] irq_o
);
  localparam int unsigned IdW = 5;
  typedef logic [31:0] vec_t;
  // Bit positions 1..NSRC of an id-indexed vector; bit 0 is never set.
  localparam vec_t SrcMask = vec_t'(((64'd1 << NSRC) - 64'd1) << 1);

  if (NSRC < 1 || NSRC > 31 || NTGT < 1 || NTGT > 8 || PRIW < 1 || PRIW > 7) begin : g_param_check
    $error("msftdvip_plic_mt: parameter out of range");
  end

  logic [PRIW-1:0] r_prio [32];
  vec_t            r_edge_mode;
  vec_t            r_en [NTGT];
  logic [PRIW-1:0] r_thr [NTGT];
  vec_t            r_pend;
  vec_t            r_blocked;
  vec_t            r_edge_mem;
  vec_t            r_irqs_q;
  logic [NTGT-1:0] r_irq;
  logic [31:0]     r_rdata;

  logic [23:0]     w_widx;
  logic            w_rd;
  logic            w_wr;
  logic            w_prio_sel;
  logic            w_pend_sel;
  logic            w_edge_sel;
  logic [NTGT-1:0] w_en_sel;
  logic [NTGT-1:0] w_thr_sel;
  logic [NTGT-1:0] w_clm_sel;
  logic            w_unused_addr;

  logic [IdW-1:0]  w_best_id [NTGT];
  logic [PRIW-1:0] w_best_pri [NTGT];
  logic [32*PRIW-1:0] w_prio_flat;
  logic [IdW-1:0]  w_claim_id;
  logic            w_cmp_id_ok;
  vec_t            w_clm_vec;
  vec_t            w_cmp_vec;
  vec_t            w_irqs;
  vec_t            w_sig;
  vec_t            w_idle;
  logic [31:0]     w_rdata;

  assign w_widx        = reg_addr_i[25:2];
  assign w_unused_addr = ^{reg_addr_i[31:26], reg_addr_i[1:0]};
  assign w_rd          = reg_en_i & ~reg_we_i;
  assign w_wr          = reg_en_i & reg_we_i;
  assign w_prio_sel    = (w_widx[23:5] == '0) && (w_widx[4:0] != '0) &&
                         (32'(w_widx[4:0]) <= NSRC);
  assign w_pend_sel    = (w_widx == 24'h000400);
  assign w_edge_sel    = (w_widx == 24'h000420);

  always_comb begin
    w_en_sel  = '0;
    w_thr_sel = '0;
    w_clm_sel = '0;
    for (int t = 0; t < NTGT; t++) begin
      w_en_sel[t]  = (w_widx == 24'h000800 + 24'(t * 32));
      w_thr_sel[t] = (w_widx == 24'h080000 + 24'(t * 1024));
      w_clm_sel[t] = (w_widx == 24'h080001 + 24'(t * 1024));
    end
  end

  // Balanced max tree over 32 leaves (leaf j = id j); on a tie the left, lower id wins.
  function automatic logic [IdW+PRIW-1:0] f_best(input vec_t elig,
                                                 input logic [32*PRIW-1:0] pri);
    logic [PRIW-1:0] n_pri [63];
    logic [IdW-1:0]  n_id  [63];
    for (int j = 0; j < 32; j++) begin
      n_pri[31+j] = elig[j] ? pri[j*PRIW +: PRIW] : '0;
      n_id[31+j]  = IdW'(j);
    end
    for (int i = 30; i >= 0; i--) begin
      if (n_pri[2*i+2] > n_pri[2*i+1]) begin
        n_pri[i] = n_pri[2*i+2];
        n_id[i]  = n_id[2*i+2];
      end else begin
        n_pri[i] = n_pri[2*i+1];
        n_id[i]  = n_id[2*i+1];
      end
    end
    return {n_id[0], n_pri[0]};
  endfunction

  always_comb begin
    w_prio_flat = '0;
    for (int j = 0; j < 32; j++) begin
      w_prio_flat[j*PRIW +: PRIW] = r_prio[j];
    end
  end

  always_comb begin
    for (int t = 0; t < NTGT; t++) begin
      {w_best_id[t], w_best_pri[t]} = f_best(r_pend & r_en[t] & SrcMask, w_prio_flat);
    end
  end

  always_comb begin
    w_claim_id = '0;
    for (int t = 0; t < NTGT; t++) begin
      if (w_clm_sel[t]) w_claim_id = w_best_id[t];
    end
  end

  // Claims and completes are mutually exclusive: one strobe is either a read or a write.
  assign w_cmp_id_ok = (reg_wdata_i[31:5] == '0) && (reg_wdata_i[4:0] != '0) &&
                       (32'(reg_wdata_i[4:0]) <= NSRC);

  always_comb begin
    w_clm_vec = '0;
    if (w_rd && (|w_clm_sel)) w_clm_vec = (vec_t'(1) << w_claim_id) & SrcMask;
    w_cmp_vec = '0;
    for (int t = 0; t < NTGT; t++) begin
      if (w_wr && w_clm_sel[t] && w_cmp_id_ok) begin
        w_cmp_vec = w_cmp_vec | (r_en[t] & (vec_t'(1) << reg_wdata_i[4:0]));
      end
    end
    w_cmp_vec = w_cmp_vec & r_blocked;
  end

  assign w_irqs = vec_t'({irqs_i, 1'b0});
  assign w_sig  = ((r_edge_mode & w_irqs & ~r_irqs_q) | (~r_edge_mode & w_irqs)) & SrcMask;
  assign w_idle = ~r_pend & ~r_blocked;

  always_comb begin
    w_rdata = '0;
    if (w_prio_sel) w_rdata = 32'(r_prio[w_widx[4:0]]);
    if (w_pend_sel) w_rdata = r_pend;
    if (w_edge_sel) w_rdata = r_edge_mode;
    for (int t = 0; t < NTGT; t++) begin
      if (w_en_sel[t])  w_rdata = r_en[t];
      if (w_thr_sel[t]) w_rdata = 32'(r_thr[t]);
      if (w_clm_sel[t]) w_rdata = 32'(w_best_id[t]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int j = 0; j < 32; j++) r_prio[j] <= '0;
      for (int t = 0; t < NTGT; t++) begin
        r_en[t]  <= '0;
        r_thr[t] <= '0;
      end
      r_edge_mode <= '0;
      r_pend      <= '0;
      r_blocked   <= '0;
      r_edge_mem  <= '0;
      r_irqs_q    <= '0;
      r_irq       <= '0;
      r_rdata     <= '0;
    end else begin
      r_irqs_q <= w_irqs;
      r_rdata  <= w_rd ? w_rdata : '0;
      // Claim wins over a same-cycle sig; a complete returns to IDLE unless an edge is held.
      r_pend     <= ((r_pend & ~w_clm_vec) | (w_idle & w_sig) | (w_cmp_vec & r_edge_mem))
                    & SrcMask;
      r_blocked  <= ((r_blocked & ~w_cmp_vec) | w_clm_vec) & SrcMask;
      r_edge_mem <= ((r_edge_mem & ~w_cmp_vec) |
                     (r_blocked & ~w_cmp_vec & r_edge_mode & w_sig)) & SrcMask;
      for (int t = 0; t < NTGT; t++) begin
        r_irq[t] <= (w_best_pri[t] > r_thr[t]);
      end
      if (w_wr) begin
        if (w_prio_sel) r_prio[w_widx[4:0]] <= reg_wdata_i[PRIW-1:0];
        if (w_edge_sel) r_edge_mode <= reg_wdata_i & SrcMask;
        for (int t = 0; t < NTGT; t++) begin
          if (w_en_sel[t])  r_en[t]  <= reg_wdata_i & SrcMask;
          if (w_thr_sel[t]) r_thr[t] <= reg_wdata_i[PRIW-1:0];
        end
      end
    end
  end

  assign reg_rdata_o = r_rdata;
  assign reg_ready_o = 1'b1;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_msftdvip_plic_mt.sv
// Self-checking bench for msftdvip_plic_mt: scenario tasks with a claim-id scoreboard queue.
module tb_msftdvip_plic_mt;
  localparam int unsigned NSRC = 31;
  localparam int unsigned NTGT = 2;
  localparam int unsigned PRIW = 3;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            reg_en_i = 1'b0;
  logic            reg_we_i = 1'b0;
  logic [31:0]     reg_addr_i = '0;
  logic [31:0]     reg_wdata_i = '0;
  logic [31:0]     reg_rdata_o;
  logic            reg_ready_o;
  logic [NSRC-1:0] irqs_i = '0;
  logic [NTGT-1:0] irq_o;

  int n_chk = 0;
  int n_fail = 0;
  int unsigned exp_q[$];
  logic [31:0] rd;
  int unsigned exp;

  msftdvip_plic_mt #(.NSRC(NSRC), .NTGT(NTGT), .PRIW(PRIW)) u_dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .reg_en_i    (reg_en_i),
    .reg_we_i    (reg_we_i),
    .reg_addr_i  (reg_addr_i),
    .reg_wdata_i (reg_wdata_i),
    .reg_rdata_o (reg_rdata_o),
    .reg_ready_o (reg_ready_o),
    .irqs_i      (irqs_i),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] APend = 32'h0000_1000;
  localparam logic [31:0] AEdge = 32'h0000_1080;
  function automatic logic [31:0] a_prio(input int id); return 32'(4 * id); endfunction
  function automatic logic [31:0] a_en(input int t); return 32'h2000 + 32'(t * 32'h80); endfunction
  function automatic logic [31:0] a_thr(input int t); return 32'h200000 + 32'(t * 32'h1000); endfunction
  function automatic logic [31:0] a_clm(input int t); return 32'h200004 + 32'(t * 32'h1000); endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    reg_en_i = 1'b1; reg_we_i = 1'b1; reg_addr_i = addr; reg_wdata_i = data;
    tick();
    reg_en_i = 1'b0; reg_we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    reg_en_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = addr;
    tick();
    reg_en_i = 1'b0;
    data = reg_rdata_o;
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    irqs_i = irqs_i | mask;
    tick();
    irqs_i = irqs_i & ~mask;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick(3);
    n_chk++;
    if (irq_o !== '0 || reg_rdata_o !== '0 || reg_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outputs: got irq=%b rdata=%h ready=%b expected 0/0/1",
               irq_o, reg_rdata_o, reg_ready_o);
    end
    rstn_i = 1'b1;
    tick();
    bus_read(APend, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", rd); end
    bus_read(a_prio(3), rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_prio: got %h expected 0", rd); end
    exp_q.push_back(0);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL reset_claim: got %0d expected %0d", rd, exp); end
  endtask

  task automatic test_level();
    bus_write(a_prio(3), 5);
    bus_write(a_en(0), 32'h1 << 3);
    bus_write(a_thr(0), 2);
    bus_read(a_prio(3), rd);
    n_chk++;
    if (rd !== 32'd5) begin n_fail++; $display("FAIL prio_rw: got %h expected 5", rd); end
    irqs_i[2] = 1'b1;
    tick();
    n_chk++;
    if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL level_latency1: got %b expected 0", irq_o[0]); end
    tick();
    n_chk++;
    if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL level_irq: got %b expected 1", irq_o[0]); end
    exp_q.push_back(3);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL level_claim: got %0d expected %0d", rd, exp); end
    tick();
    n_chk++;
    if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL level_irq_drop: got %b expected 0", irq_o[0]); end
    bus_write(a_clm(0), 3);
    tick();
    n_chk++;
    if (irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL level_repend_lat: got %b expected 0", irq_o[0]); end
    tick();
    n_chk++;
    if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL level_repend: got %b expected 1", irq_o[0]); end
    exp_q.push_back(3);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL level_claim2: got %0d expected %0d", rd, exp); end
    irqs_i[2] = 1'b0;
    bus_write(a_clm(0), 3);
    bus_write(a_en(0), 0);
  endtask

  task automatic test_tie_break();
    bus_write(a_prio(4), 6);
    bus_write(a_prio(9), 6);
    bus_write(a_en(0), (32'h1 << 4) | (32'h1 << 9));
    pulse((31'h1 << 3) | (31'h1 << 8));
    bus_read(APend, rd);
    n_chk++;
    if (rd !== 32'h210) begin n_fail++; $display("FAIL tie_pending: got %h expected 210", rd); end
    exp_q.push_back(4); exp_q.push_back(9); exp_q.push_back(0);
    repeat (3) begin
      bus_read(a_clm(0), rd);
      exp = exp_q.pop_front();
      n_chk++;
      if (rd !== exp) begin n_fail++; $display("FAIL tie_claim: got %0d expected %0d", rd, exp); end
    end
    bus_write(a_clm(0), 4);
    bus_write(a_clm(0), 9);
    pulse((31'h1 << 3) | (31'h1 << 8));
    bus_write(a_prio(9), 7);
    exp_q.push_back(9); exp_q.push_back(4);
    repeat (2) begin
      bus_read(a_clm(0), rd);
      exp = exp_q.pop_front();
      n_chk++;
      if (rd !== exp) begin n_fail++; $display("FAIL prio_claim: got %0d expected %0d", rd, exp); end
    end
    bus_write(a_clm(0), 4);
    bus_write(a_clm(0), 9);
    bus_write(a_en(0), 0);
  endtask

  task automatic test_edge_memory();
    bus_write(AEdge, 32'h1 << 7);
    bus_write(a_prio(7), 3);
    bus_write(a_en(0), 32'h1 << 7);
    pulse(31'h1 << 6);
    exp_q.push_back(7);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL edge_claim1: got %0d expected %0d", rd, exp); end
    pulse(31'h1 << 6);
    tick();
    pulse(31'h1 << 6);
    tick();
    bus_read(APend, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL edge_blocked_pend: got %h expected 0", rd); end
    bus_write(a_clm(0), 7);
    bus_read(APend, rd);
    n_chk++;
    if (rd !== (32'h1 << 7)) begin n_fail++; $display("FAIL edge_mem_pend: got %h expected 80", rd); end
    exp_q.push_back(7);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL edge_claim2: got %0d expected %0d", rd, exp); end
    bus_write(a_clm(0), 7);
    exp_q.push_back(0);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL edge_single: got %0d expected %0d", rd, exp); end
    bus_write(a_en(0), 0);
    bus_write(AEdge, 0);
  endtask

  task automatic test_threshold();
    bus_write(a_prio(2), 4);
    bus_write(a_en(0), 32'h1 << 2);
    bus_write(a_thr(0), 4);
    pulse(31'h1 << 1);
    tick(2);
    n_chk++;
    if (irq_o !== 2'b00) begin n_fail++; $display("FAIL thr_mask: got %b expected 00", irq_o); end
    bus_write(a_en(1), 32'h1 << 2);
    bus_write(a_thr(1), 1);
    tick(2);
    n_chk++;
    if (irq_o !== 2'b10) begin n_fail++; $display("FAIL thr_tgt1: got %b expected 10", irq_o); end
    exp_q.push_back(2);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL thr_claim: got %0d expected %0d", rd, exp); end
    tick();
    n_chk++;
    if (irq_o !== 2'b00) begin n_fail++; $display("FAIL thr_after_claim: got %b expected 00", irq_o); end
    bus_write(a_clm(0), 2);
    bus_write(a_en(0), 0);
    bus_write(a_en(1), 0);
  endtask

  task automatic test_bad_complete();
    bus_write(a_prio(10), 2);
    bus_write(a_prio(11), 1);
    bus_write(a_en(0), (32'h1 << 10) | (32'h1 << 11));
    pulse(31'h1 << 9);
    exp_q.push_back(10);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL bad_claim10: got %0d expected %0d", rd, exp); end
    pulse(31'h1 << 10);
    bus_write(a_clm(0), 0);
    bus_write(a_clm(0), 40);
    bus_write(a_clm(0), 42);
    bus_write(a_clm(0), 11);
    bus_write(a_clm(1), 10);
    pulse(31'h1 << 9);
    tick();
    bus_read(APend, rd);
    n_chk++;
    if (rd !== (32'h1 << 11)) begin n_fail++; $display("FAIL bad_cmp_pend: got %h expected 800", rd); end
    exp_q.push_back(11);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL bad_cmp_claim: got %0d expected %0d", rd, exp); end
    bus_write(a_clm(0), 11);
    bus_write(a_clm(0), 10);
    pulse(31'h1 << 9);
    bus_read(APend, rd);
    n_chk++;
    if (rd !== (32'h1 << 10)) begin n_fail++; $display("FAIL good_cmp_pend: got %h expected 400", rd); end
    exp_q.push_back(10);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL good_cmp_claim: got %0d expected %0d", rd, exp); end
    bus_write(a_clm(0), 10);
    bus_write(a_en(0), 0);
  endtask

  task automatic test_reset_mid_claim();
    bus_write(a_prio(5), 3);
    bus_write(a_en(0), 32'h1 << 5);
    bus_write(a_thr(0), 0);
    irqs_i[4] = 1'b1;
    tick(2);
    n_chk++;
    if (irq_o[0] !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq: got %b expected 1", irq_o[0]); end
    exp_q.push_back(5);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL rst_pre_claim: got %0d expected %0d", rd, exp); end
    reg_en_i = 1'b1; reg_we_i = 1'b0; reg_addr_i = a_clm(0);
    #2;
    rstn_i = 1'b0;
    #1;
    n_chk++;
    if (irq_o !== '0 || reg_rdata_o !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got irq=%b rdata=%h expected 0/0", irq_o, reg_rdata_o);
    end
    reg_en_i = 1'b0;
    tick(2);
    @(negedge clk_i);
    rstn_i = 1'b1;
    tick(3);
    bus_read(APend, rd);
    n_chk++;
    if (rd !== (32'h1 << 5)) begin n_fail++; $display("FAIL rst_repend: got %h expected 20", rd); end
    n_chk++;
    if (irq_o !== 2'b00) begin n_fail++; $display("FAIL rst_no_irq: got %b expected 00", irq_o); end
    bus_write(a_prio(5), 3);
    tick(2);
    n_chk++;
    if (irq_o !== 2'b00) begin n_fail++; $display("FAIL rst_prio_only: got %b expected 00", irq_o); end
    bus_write(a_en(0), 32'h1 << 5);
    tick(2);
    n_chk++;
    if (irq_o !== 2'b01) begin n_fail++; $display("FAIL rst_reprog_irq: got %b expected 01", irq_o); end
    exp_q.push_back(5);
    bus_read(a_clm(0), rd);
    exp = exp_q.pop_front();
    n_chk++;
    if (rd !== exp) begin n_fail++; $display("FAIL rst_post_claim: got %0d expected %0d", rd, exp); end
    irqs_i[4] = 1'b0;
    bus_write(a_clm(0), 5);
  endtask

  initial begin
    test_reset();
    test_level();
    test_tie_break();
    test_edge_memory();
    test_threshold();
    test_bad_complete();
    test_reset_mid_claim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
